// File: rtl/conv_window_gen.sv
// conv_window_gen: streaming 3x3 window generator with two line buffers and held kernel/bias; CONV_STRIDE2_EN selects stride-2 windows
module conv_window_gen #(
  parameter int IMG_W = 28,
  parameter int IMG_H = 28
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic        pix_valid,
  input  logic [7:0]  pix_in,
  input  logic        weight_load,
  input  logic [35:0] weight_in,
  input  logic [4:0]  exp_bias_in,
  output logic [71:0] image,
  output logic [35:0] weight,
  output logic [4:0]  exp_bias,
  output logic        win_valid,
  output logic        frame_done
);
  localparam int CW = $clog2(IMG_W);
  localparam int RW = $clog2(IMG_H);
`ifdef CONV_STRIDE2_EN
  localparam int LC = IMG_W - 1 - ((IMG_W - 1) % 2);
  localparam int LR = IMG_H - 1 - ((IMG_H - 1) % 2);
`else
  localparam int LC = IMG_W - 1;
  localparam int LR = IMG_H - 1;
`endif
  localparam logic [CW-1:0] CMAX = CW'(IMG_W - 1);
  localparam logic [CW-1:0] CLAST = CW'(LC);
  localparam logic [CW-1:0] C2 = CW'(2);
  localparam logic [RW-1:0] RMAX = RW'(IMG_H - 1);
  localparam logic [RW-1:0] RLAST = RW'(LR);
  localparam logic [RW-1:0] R2 = RW'(2);
  logic [CW-1:0] col, c, c_nx;
  logic [RW-1:0] row, r, r_nx;
  logic          hit, last;
  logic [7:0]    lb1 [IMG_W];
  logic [7:0]    lb2 [IMG_W];
  // frame_start makes the current pixel (0,0) regardless of where the counters are
  always_comb begin
    c = frame_start ? '0 : col;
    r = frame_start ? '0 : row;
    c_nx = (c == CMAX) ? '0 : c + 1'b1;
    r_nx = (c != CMAX) ? r : (r == RMAX) ? '0 : r + 1'b1;
`ifdef CONV_STRIDE2_EN
    hit = (r >= R2) && (c >= C2) && !r[0] && !c[0];
`else
    hit = (r >= R2) && (c >= C2);
`endif
    last = (r == RLAST) && (c == CLAST);
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      col <= '0;
      row <= '0;
      image <= '0;
      win_valid <= 1'b0;
      frame_done <= 1'b0;
    end else begin
      win_valid <= pix_valid && hit;
      frame_done <= pix_valid && hit && last;
      if (pix_valid) begin
        col <= c_nx;
        row <= r_nx;
        image <= {image[63:48], lb2[c], image[39:24], lb1[c], image[15:0], pix_in};
      end
    end
  // line buffers are never reset; the row>=2 rule keeps stale data out of windows
  always_ff @(posedge clk)
    if (pix_valid) begin
      lb2[c] <= lb1[c];
      lb1[c] <= pix_in;
    end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      weight <= '0;
      exp_bias <= '0;
    end else if (weight_load) begin
      weight <= weight_in;
      exp_bias <= exp_bias_in;
    end
endmodule

// File: tb/tb_conv_window_gen.sv
// tb_conv_window_gen: scoreboard bench for conv_window_gen (4x4 and 6x6 instances)
module tb_conv_window_gen;
  localparam int W = 4;
  localparam int H = 4;
`ifdef CONV_STRIDE2_EN
  localparam int WPF = 1;
  localparam int NB_EXP = 4;
  localparam logic [71:0] LAST_B = 72'h0E0F10_141516_1A1B1C;
`else
  localparam int WPF = 4;
  localparam int NB_EXP = 16;
  localparam logic [71:0] LAST_B = 72'h151617_1B1C1D_212223;
`endif
  typedef logic [113:0] exp_t;
  logic clk = 0, rst = 0, frame_start = 0, pix_valid = 0, weight_load = 0;
  logic [7:0] pix_in = 0;
  logic [35:0] weight_in = 0, weight;
  logic [4:0] exp_bias_in = 0, exp_bias;
  logic [71:0] image;
  logic win_valid, frame_done;
  logic pv_b = 0;
  logic [7:0] pix_b = 0;
  logic [71:0] img_b, first_b, last_b;
  logic [35:0] wt_b;
  logic [4:0] eb_b;
  logic wv_b, fd_b, last_fd_b;
  int checks = 0, errors = 0, nwin = 0, nfd = 0, nb = 0, fdb = 0;
  int mrow = 0, mcol = 0, lr = 0, lc = 0, n0, f0;
  logic [35:0] mw = 0;
  logic [4:0] mb = 0;
  logic [7:0] fr [H][W];
  exp_t q[$];
  exp_t e;
  conv_window_gen #(.IMG_W(W), .IMG_H(H)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .pix_valid(pix_valid), .pix_in(pix_in),
    .weight_load(weight_load), .weight_in(weight_in), .exp_bias_in(exp_bias_in),
    .image(image), .weight(weight), .exp_bias(exp_bias), .win_valid(win_valid), .frame_done(frame_done));
  conv_window_gen #(.IMG_W(6), .IMG_H(6)) dut_b (
    .clk(clk), .rst(rst), .frame_start(1'b0), .pix_valid(pv_b), .pix_in(pix_b),
    .weight_load(1'b0), .weight_in(36'h0), .exp_bias_in(5'h0),
    .image(img_b), .weight(wt_b), .exp_bias(eb_b), .win_valid(wv_b), .frame_done(fd_b));
  always #5 clk = ~clk;
  function automatic bit is_win(int r, int c);
    bit s = 1;
`ifdef CONV_STRIDE2_EN
    s = (r % 2 == 0) && (c % 2 == 0);
`endif
    return r >= 2 && c >= 2 && s;
  endfunction
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask
  task automatic model(input logic [7:0] p, input logic fs);
    int r, c;
    logic [71:0] win;
    r = fs ? 0 : mrow;
    c = fs ? 0 : mcol;
    fr[r][c] = p;
    if (is_win(r, c)) begin
      for (int i = 0; i < 3; i++)
        for (int j = 0; j < 3; j++)
          win[71 - 8 * (3 * i + j) -: 8] = fr[r - 2 + i][c - 2 + j];
      q.push_back({win, (r == lr && c == lc), mw, mb});
    end
    mrow = (c == W - 1) ? ((r == H - 1) ? 0 : r + 1) : r;
    mcol = (c == W - 1) ? 0 : c + 1;
  endtask
  task automatic px(input logic [7:0] p, input logic fs = 0, input logic wl = 0,
                    input logic [35:0] w = 0, input logic [4:0] b = 0);
    pix_valid = 1; pix_in = p; frame_start = fs;
    weight_load = wl; weight_in = w; exp_bias_in = b;
    if (wl) begin mw = w; mb = b; end
    model(p, fs);
    @(posedge clk); #1;
    pix_valid = 0; frame_start = 0; weight_load = 0;
  endtask
  task automatic idle(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask
  task automatic frame(input int from, input int to);
    for (int i = from; i <= to; i++) px(8'(i));
  endtask
  always @(negedge clk) begin
    checks++;
    if (win_valid) begin
      assert (q.size() > 0) else begin
        errors++;
        $error("FAIL extra_window got=%h exp=none", image);
      end
      if (q.size() > 0) begin
        e = q.pop_front();
        assert ({image, frame_done, weight, exp_bias} === e) else begin
          errors++;
          $error("FAIL window got=%h exp=%h", {image, frame_done, weight, exp_bias}, e);
        end
        nwin++;
        if (frame_done) nfd++;
      end
    end else begin
      assert (frame_done === 1'b0) else begin
        errors++;
        $error("FAIL stray_frame_done got=%b exp=0", frame_done);
      end
    end
  end
  always @(negedge clk)
    if (wv_b) begin
      nb++;
      if (nb == 1) first_b = img_b;
      last_b = img_b;
      last_fd_b = fd_b;
      if (fd_b) fdb++;
    end
  initial begin
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++)
        if (is_win(r, c)) begin lr = r; lc = c; end
    #2 rst = 1;
    #1;
    chk("rst_image", image, 0);
    chk("rst_valid", {win_valid, frame_done}, 0);
    chk("rst_weight", {weight, exp_bias}, 0);
    @(posedge clk); #1 rst = 0;
    // basic frame
    frame(0, 9);
    chk("no_win_2_1", win_valid, 0);
    px(8'h0A);
    chk("first_valid", win_valid, 1);
    chk("first_image", image, 72'h000102_040506_08090A);
    frame(11, 15);
`ifndef CONV_STRIDE2_EN
    chk("last_image", image, 72'h050607_090A0B_0D0E0F);
    chk("last_done", frame_done, 1);
`endif
    idle(1);
    chk("basic_count", nwin, WPF);
    // stall between 0x09 and 0x0A
    frame(0, 9);
    for (int i = 0; i < 3; i++) begin
      idle(1);
      chk("stall_valid", win_valid, 0);
      chk("stall_image", image, 72'h0F0001_030405_070809);
    end
    frame(10, 15);
    idle(1);
    chk("stall_count", nwin, 2 * WPF);
    // partial frame then restart
    frame(0, 6);
    px(8'h00, 1);
    frame(1, 15);
    idle(1);
    chk("restart_count", nwin, 3 * WPF);
    chk("restart_done", nfd, 3);
    // weights
    pix_valid = 0; weight_load = 1; weight_in = 36'h123456789; exp_bias_in = 5'h0F;
    mw = 36'h123456789; mb = 5'h0F;
    @(posedge clk); #1 weight_load = 0;
    chk("wload_weight", weight, 36'h123456789);
    chk("wload_bias", exp_bias, 5'h0F);
    frame_start = 1;
    idle(1);
    frame_start = 0;
    frame(0, 9);
    chk("weight_held", {weight, exp_bias}, {36'h123456789, 5'h0F});
    px(8'h0A, 0, 1, 36'hABCDEF012, 5'h15);
    chk("simul_weight", weight, 36'hABCDEF012);
    frame(11, 15);
    idle(1);
    chk("weight_count", nwin, 4 * WPF);
    chk("weight_after", {weight, exp_bias}, {36'hABCDEF012, 5'h15});
    // back-to-back frames
    n0 = nwin; f0 = nfd;
    frame(0, 15);
    frame(0, 15);
    idle(1);
    chk("b2b_count", nwin - n0, 2 * WPF);
    chk("b2b_done", nfd - f0, 2);
    // reset mid-frame right after a window
    frame(0, 10);
    @(negedge clk); #1 rst = 1;
    #1;
    chk("mid_rst_valid", win_valid, 0);
    chk("mid_rst_image", image, 0);
    chk("mid_rst_weight", {weight, exp_bias}, 0);
    mrow = 0; mcol = 0; mw = 0; mb = 0;
    @(posedge clk); #1 rst = 0;
    n0 = nwin;
    frame(0, 15);
    idle(2);
    chk("post_rst_count", nwin - n0, WPF);
    chk("queue_empty", q.size(), 0);
    // 6x6 instance
    for (int i = 0; i < 36; i++) begin
      pv_b = 1; pix_b = 8'(i);
      @(posedge clk); #1;
    end
    pv_b = 0;
    idle(2);
    chk("b_count", nb, NB_EXP);
    chk("b_first", first_b, 72'h000102_060708_0C0D0E);
    chk("b_last", last_b, LAST_B);
    chk("b_last_done", last_fd_b, 1);
    chk("b_done_count", fdb, 1);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
